// File: rtl/arb_req_pkg.sv
// Shared definitions for the arbiter requester agent.
// Holds the one-hot state encodings, the state enum and the default job
// length width used by arb_requester.
package arb_req_pkg;

  localparam int ARB_REQ_LEN_W = 4;

  localparam logic [3:0] ST_IDLE    = 4'b0001;
  localparam logic [3:0] ST_REQ     = 4'b0010;
  localparam logic [3:0] ST_XFER    = 4'b0100;
  localparam logic [3:0] ST_RELEASE = 4'b1000;

  typedef enum logic [3:0] {
    S_IDLE    = ST_IDLE,
    S_REQ     = ST_REQ,
    S_XFER    = ST_XFER,
    S_RELEASE = ST_RELEASE
  } arb_req_state_t;

endpackage

// File: rtl/arb_req_wait_timer.sv
// Saturating wait counter for the REQ phase of arb_requester.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - restart the count from zero (job accepted)
//   en        - count this cycle (requesting without grant)
//   expired   - count has reached MAX_WAIT-1, i.e. this is the last
//               allowed cycle without a grant
// The count stops at MAX_WAIT and never wraps.
module arb_req_wait_timer #(
  parameter int MAX_WAIT = 64,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wait_cnt <= '0;
    end else if (en && (wait_cnt != WAIT_W'(MAX_WAIT))) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign expired = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/arb_requester.sv
// Requester-side agent for a two-port req/gnt fixed-priority arbiter.
// Accepts a job (beat count minus one), raises req, streams exactly
// job_len+1 granted beats, then drops req and waits for gnt to fall
// before taking new work.
// Optional: define ARB_REQ_TIMEOUT_EN to give up after MAX_WAIT cycles
// in REQ without a grant (timeout pulse); otherwise timeout is tied 0.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   job_valid   - local job offered        job_ready - can accept a job
//   job_len     - beats minus one
//   req         - request to arbiter       gnt       - grant from arbiter
//   beat_valid  - granted data beat        beat_idx  - current beat index
//   done        - pulse: job completed     abort     - pulse: gnt lost
//   timeout     - pulse: REQ wait expired  busy      - not idle
module arb_requester
  import arb_req_pkg::*;
#(
  parameter int LEN_W    = ARB_REQ_LEN_W,
  parameter int MAX_WAIT = 64,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LEN_W-1:0] job_len,
  output logic             req,
  input  logic             gnt,
  output logic             beat_valid,
  output logic [LEN_W-1:0] beat_idx,
  output logic             done,
  output logic             abort,
  output logic             timeout,
  output logic             busy
);

  arb_req_state_t   state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic             accept;
  logic             wait_expired;

`ifdef ARB_REQ_TIMEOUT_EN
  logic timer_hit;
  logic timeout_q;

  arb_req_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      ((state == S_REQ) && !gnt),
    .expired (timer_hit)
  );

  assign wait_expired = timer_hit && !gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state == S_REQ) && wait_expired;
    end
  end

  assign timeout = timeout_q;
`else
  logic [WAIT_W-1:0] unused_max_wait;

  assign unused_max_wait = WAIT_W'(MAX_WAIT);
  assign wait_expired    = 1'b0;
  assign timeout         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are gated with rst so the port is quiet for the whole reset
  // cycle, not only after the state register has been cleared.
  always_comb begin
    state_nxt  = state;
    job_ready  = 1'b0;
    req        = 1'b0;
    beat_valid = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy      = 1'b0;
        job_ready = !rst;
        accept    = job_valid && !rst;
        if (accept) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        req = !rst;
        // A grant arriving on the last wait cycle still wins.
        if (gnt) begin
          state_nxt = S_XFER;
        end else if (wait_expired) begin
          state_nxt = S_RELEASE;
        end
      end
      S_XFER: begin
        req        = !rst;
        beat_valid = gnt && !rst;
        if (!gnt || (beat_idx == len_q)) begin
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!gnt) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      beat_idx <= '0;
      done     <= 1'b0;
      abort    <= 1'b0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            len_q <= job_len;
          end
        end
        S_REQ: begin
          if (gnt) begin
            beat_idx <= '0;
          end
        end
        S_XFER: begin
          if (!gnt) begin
            abort <= 1'b1;
          end else if (beat_idx == len_q) begin
            done <= 1'b1;
          end else begin
            beat_idx <= beat_idx + LEN_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
